// File: rtl/uart_frame_loader_pkg.sv
// Shared types and constants for the UART frame loader and the datapath's
// uart_sel decode.
package uart_frame_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_CSUM
    } state_e;

    // Target codes; the datapath decodes uart_sel with these exact values.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_INST = 2'd2;

    localparam logic [7:0] DEF_HDR_MEM  = 8'hA1;
    localparam logic [7:0] DEF_HDR_INST = 8'hA2;

endpackage

// File: rtl/uart_frame_loader_idle_timer.sv
// Inter-byte idle timer: counts cycles while run is high and no clear arrives,
// and flags the cycle whose edge would bring the count to LIMIT.
module uart_idle_timer #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // A clear in the same cycle suppresses expiry, so an arriving byte wins.
    assign expired = run && !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear || !run) begin
            count_d = '0;
        end else if (count_q != TOP) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses header/length/payload/checksum byte frames from the UART receiver
// and emits big-endian 16-bit words towards the datapath load port.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HDR_MEM        = DEF_HDR_MEM,
    parameter logic [7:0]  HDR_INST       = DEF_HDR_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        uart_en,
    output logic [1:0]  uart_sel,
    output logic [15:0] uart_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  sel_q, sel_d;
    logic        en_q, en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        timer_expired;

    assign busy       = (state_q != ST_IDLE);
    assign uart_en    = en_q;
    assign uart_sel   = sel_q;
    assign uart_data  = data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

    uart_idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .run    (busy),
        .expired(timer_expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        hi_d    = hi_q;
        data_d  = data_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;

        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == HDR_MEM || rx_data == HDR_INST) begin
                        sel_d   = (rx_data == HDR_MEM) ? SEL_MEM : SEL_INST;
                        err_d   = 1'b0;
                        csum_d  = 8'h00;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_data == 8'h00) begin
                        err_d   = 1'b1;
                        sel_d   = SEL_NONE;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = rx_data;
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    data_d  = {hi_q, rx_data};
                    csum_d  = csum_q ^ rx_data;
                    en_d    = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? ST_CSUM : ST_HI;
                end
                ST_CSUM: begin
                    if (rx_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    sel_d   = SEL_NONE;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timer_expired) begin
            err_d   = 1'b1;
            sel_d   = SEL_NONE;
            hi_d    = 8'h00;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
            csum_q  <= 8'h00;
            hi_q    <= 8'h00;
            data_q  <= 16'h0000;
            sel_q   <= SEL_NONE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomised and directed frame stimulus for uart_frame_loader, checked every
// cycle against expectations derived from the frame contents.
module tb_uart_frame_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        uart_en;
    logic [1:0]  uart_sel;
    logic [15:0] uart_data;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    always #5 clk = ~clk;

    uart_frame_loader #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .uart_en   (uart_en),
        .uart_sel  (uart_sel),
        .uart_data (uart_data),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs after the next edge (n_*) and after the last edge (c_*).
    logic        n_en, n_done, n_err, n_busy, n_arm;
    logic [1:0]  n_sel;
    logic [15:0] n_data;
    logic        c_en, c_done, c_err, c_busy, c_arm;
    logic [1:0]  c_sel;
    logic [15:0] c_data;

    logic [17:0] evq[$];
    int          done_cnt;
    logic [15:0] fw[256];

    always @(posedge clk) begin
        c_en   <= n_en;
        c_done <= n_done;
        c_err  <= n_err;
        c_busy <= n_busy;
        c_sel  <= n_sel;
        c_data <= n_data;
        c_arm  <= n_arm;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (c_arm === 1'b1) begin
            chk("uart_en",    32'(uart_en),    32'(c_en));
            chk("uart_data",  32'(uart_data),  32'(c_data));
            chk("uart_sel",   32'(uart_sel),   32'(c_sel));
            chk("busy",       32'(busy),       32'(c_busy));
            chk("frame_done", 32'(frame_done), 32'(c_done));
            chk("frame_err",  32'(frame_err),  32'(c_err));
            if (uart_en === 1'b1) evq.push_back({uart_sel, uart_data});
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    function automatic logic [17:0] ev(input int i);
        return (i < evq.size()) ? evq[i] : 18'h3ffff;
    endfunction

    task automatic cyc(input bit v, input logic [7:0] d, input bit r = 1'b0);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        reset    = r;
        n_en     = 1'b0;
        n_done   = 1'b0;
        if (r) begin
            n_data = 16'h0000;
            n_sel  = 2'd0;
            n_busy = 1'b0;
            n_err  = 1'b0;
        end
    endtask

    task automatic gap(input int maxgap);
        int g;
        g = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
        repeat (g) cyc(1'b0, 8'h00);
    endtask

    task automatic settle();
        cyc(1'b0, 8'h00);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        evq.delete();
        done_cnt = 0;
    endtask

    // Sends one frame built from fw[0..n-1]; ov >= 0 forces the checksum byte.
    task automatic send_frame(input logic [7:0] hdr, input int n, input int maxgap,
                              input bit bad, input int ov);
        logic [7:0] cs;
        logic [7:0] sent;
        cs = 8'h00;
        gap(maxgap);
        cyc(1'b1, hdr);
        n_sel  = (hdr == 8'hA1) ? 2'd1 : 2'd2;
        n_busy = 1'b1;
        n_err  = 1'b0;
        gap(maxgap);
        cyc(1'b1, 8'(n));
        if (n == 0) begin
            n_err  = 1'b1;
            n_busy = 1'b0;
            n_sel  = 2'd0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            gap(maxgap);
            cyc(1'b1, fw[i][15:8]);
            gap(maxgap);
            cyc(1'b1, fw[i][7:0]);
            n_en   = 1'b1;
            n_data = fw[i];
            cs     = cs ^ fw[i][15:8] ^ fw[i][7:0];
        end
        if (ov >= 0)  sent = 8'(ov);
        else if (bad) sent = cs ^ 8'($urandom_range(1, 255));
        else          sent = cs;
        gap(maxgap);
        cyc(1'b1, sent);
        if (sent == cs) n_done = 1'b1;
        else            n_err  = 1'b1;
        n_busy = 1'b0;
        n_sel  = 2'd0;
    endtask

    initial begin
        logic [7:0] g;
        int         n;
        int         mg;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        n_en = 0; n_done = 0; n_err = 0; n_busy = 0; n_sel = 0; n_data = 0; n_arm = 0;
        done_cnt = 0;

        cyc(1'b0, 8'h00, 1'b1);
        n_arm = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        chk("reset_busy",  32'(busy),      32'd0);
        chk("reset_sel",   32'(uart_sel),  32'd0);
        chk("reset_data",  32'(uart_data), 32'h0000);
        chk("reset_err",   32'(frame_err), 32'd0);

        // Instruction frame with matching checksum 0x40
        clear_log();
        fw[0] = 16'h1234; fw[1] = 16'hABCD;
        send_frame(8'hA2, 2, 0, 1'b0, 8'h40);
        settle();
        chk("inst_words",  32'(evq.size()), 32'd2);
        chk("inst_word0",  32'(ev(0)), 32'({2'd2, 16'h1234}));
        chk("inst_word1",  32'(ev(1)), 32'({2'd2, 16'hABCD}));
        chk("inst_done",   32'(done_cnt), 32'd1);
        chk("inst_err",    32'(frame_err), 32'd0);

        // Data frame with bad checksum, then a clean frame clears the error
        clear_log();
        fw[0] = 16'hBEEF;
        send_frame(8'hA1, 1, 0, 1'b0, 8'h00);
        settle();
        chk("bad_words",   32'(evq.size()), 32'd1);
        chk("bad_word0",   32'(ev(0)), 32'({2'd1, 16'hBEEF}));
        chk("bad_err",     32'(frame_err), 32'd1);
        chk("bad_done",    32'(done_cnt), 32'd0);
        clear_log();
        fw[0] = 16'h0102;
        send_frame(8'hA1, 1, 0, 1'b0, -1);
        settle();
        chk("recover_err", 32'(frame_err), 32'd0);
        chk("recover_done", 32'(done_cnt), 32'd1);

        // Garbage byte then zero length
        clear_log();
        cyc(1'b1, 8'h55);
        settle();
        chk("garbage_busy", 32'(busy), 32'd0);
        send_frame(8'hA2, 0, 0, 1'b0, -1);
        settle();
        chk("len0_err",    32'(frame_err), 32'd1);
        chk("len0_words",  32'(evq.size()), 32'd0);

        // Timeout 16 cycles after the last byte
        clear_log();
        cyc(1'b1, 8'hA1); n_sel = 2'd1; n_busy = 1'b1; n_err = 1'b0;
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h12);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 8'h00);
            if (i == 16) begin
                n_busy = 1'b0; n_err = 1'b1; n_sel = 2'd0;
            end
        end
        settle();
        chk("tmo_err",     32'(frame_err), 32'd1);
        chk("tmo_busy",    32'(busy), 32'd0);
        chk("tmo_words",   32'(evq.size()), 32'd0);

        // Byte arriving on the edge the timeout would fire wins
        clear_log();
        cyc(1'b1, 8'hA1); n_sel = 2'd1; n_busy = 1'b1; n_err = 1'b0;
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h12);
        repeat (15) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h34); n_en = 1'b1; n_data = 16'h1234;
        cyc(1'b1, 8'h26); n_done = 1'b1; n_busy = 1'b0; n_sel = 2'd0;
        settle();
        chk("race_word",   32'(ev(0)), 32'({2'd1, 16'h1234}));
        chk("race_done",   32'(done_cnt), 32'd1);

        // Back-to-back N=3 frame, then a repeat interrupted by reset
        clear_log();
        fw[0] = 16'h1122; fw[1] = 16'h3344; fw[2] = 16'h5566;
        send_frame(8'hA2, 3, 0, 1'b0, -1);
        settle();
        chk("b2b_words",   32'(evq.size()), 32'd3);
        chk("b2b_word0",   32'(ev(0)), 32'({2'd2, 16'h1122}));
        chk("b2b_word1",   32'(ev(1)), 32'({2'd2, 16'h3344}));
        chk("b2b_word2",   32'(ev(2)), 32'({2'd2, 16'h5566}));
        clear_log();
        cyc(1'b1, 8'hA2); n_sel = 2'd2; n_busy = 1'b1; n_err = 1'b0;
        cyc(1'b1, 8'h03);
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22); n_en = 1'b1; n_data = 16'h1122;
        cyc(1'b1, 8'h33);
        cyc(1'b1, 8'h44); n_en = 1'b1; n_data = 16'h3344;
        cyc(1'b1, 8'h55, 1'b1);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h66);
        cyc(1'b1, 8'h77);
        settle();
        chk("rst_words",   32'(evq.size()), 32'd2);
        chk("rst_data",    32'(uart_data), 32'h0000);
        chk("rst_busy",    32'(busy), 32'd0);

        // Randomised frames with random gaps, errors and garbage
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                do g = 8'($urandom_range(0, 255)); while (g == 8'hA1 || g == 8'hA2);
                cyc(1'b1, g);
            end
            n  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            mg = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) fw[i] = 16'($urandom);
            send_frame($urandom_range(0, 1) ? 8'hA1 : 8'hA2, n, mg,
                       ($urandom_range(0, 3) == 0), -1);
        end
        settle();
        repeat (3) cyc(1'b0, 8'h00);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
